sha_byte_feeder: RTL and testbench

- Transmit-side adapter that drives the byte-stream input of the sha224/sha256 cores (tvalid/tready/tlast/tid/tdata).
- Accepts 32-bit words with a per-word byte count from a word-wide upstream source.
- Serialises each word most-significant byte first, preserving SHA message byte order.
- Holds tid for the whole message, asserts tlast on the final byte, and optionally inserts idle cycles between messages.

---
 rtl/sha_byte_feeder.sv | 147 ++++++++++++++
 tb/tb_sha_byte_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_byte_feeder.sv
// Serialises 32-bit upstream words MSB-first onto the SHA core byte stream; first byte one cycle after accept.
// tready low holds the current byte; i_ready only rises when the buffer frees, with optional idle gap after each message.
module sha_byte_feeder #(
  parameter int GAP      = 0,
  parameter int ID_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic                i_last,
  input  logic [ID_WIDTH-1:0] i_id,
  input  logic [31:0]         i_data,
  input  logic [1:0]          i_nbytes,
  output logic                tvalid,
  input  logic                tready,
  output logic                tlast,
  output logic [ID_WIDTH-1:0] tid,
  output logic [7:0]          tdata,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

  localparam logic       HAS_GAP = (GAP > 0);
  localparam logic [7:0] GAP_CNT = 8'(GAP);

  state_e                state_q, state_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            nbytes_q, nbytes_d;
  logic                  wlast_q, wlast_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  first_q, first_d;
  logic                  busy_q, busy_d;

  logic                  send;
  logic                  end_word;
  logic                  hs;
  logic                  load;
  logic                  first_eff;
  logic [7:0]            byte_sel;

  assign send     = (state_q == S_SEND);
  assign end_word = (idx_q == nbytes_q);
  assign hs       = send & tready;

  // Buffer frees on the final-byte handshake unless a gap must follow the message.
  assign i_ready = rstn & ((state_q == S_IDLE) |
                           (send & tready & end_word & ~(wlast_q & HAS_GAP)));

  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      2'd0: byte_sel = word_q[31:24];
      2'd1: byte_sel = word_q[23:16];
      2'd2: byte_sel = word_q[15:8];
      2'd3: byte_sel = word_q[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  assign tvalid = send;
  assign tdata  = send ? byte_sel : 8'h00;
  assign tlast  = send & wlast_q & end_word;
  assign tid    = send ? id_q : '0;
  assign busy   = busy_q;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    nbytes_d  = nbytes_q;
    wlast_d   = wlast_q;
    id_d      = id_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    first_d   = first_q;
    load      = 1'b0;
    first_eff = first_q;

    case (state_q)
      S_IDLE: begin
        load = i_valid;
      end
      S_SEND: begin
        if (hs) begin
          if (!end_word) begin
            idx_d = idx_q + 2'd1;
          end else if (wlast_q && HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_CNT;
            first_d   = 1'b1;
          end else begin
            // A word following the last byte opens a new message and takes a fresh id.
            if (wlast_q) first_eff = 1'b1;
            first_d = first_eff;
            if (i_valid) load = 1'b1;
            else         state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d  = S_SEND;
      word_d   = i_data;
      nbytes_d = i_nbytes;
      wlast_d  = i_last;
      idx_d    = 2'd0;
      first_d  = 1'b0;
      if (first_eff) id_d = i_id;
    end

    busy_d = (state_d != S_IDLE) | ~first_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      nbytes_q  <= '0;
      wlast_q   <= 1'b0;
      id_q      <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      nbytes_q  <= nbytes_d;
      wlast_q   <= wlast_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_sha_byte_feeder.sv
// Directed bench for sha_byte_feeder: one instance with GAP=0, one with GAP=3.
module tb_sha_byte_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        iv = 1'b0, il = 1'b0, trdy = 1'b0;
  logic        ir, tv, tl, busy;
  logic [31:0] iid = '0, idat = '0, tid;
  logic [1:0]  inb = '0;
  logic [7:0]  td;

  logic        g_iv = 1'b0, g_il = 1'b0, g_trdy = 1'b0;
  logic        g_ir, g_tv, g_tl, g_busy;
  logic [31:0] g_iid = '0, g_idat = '0, g_tid;
  logic [1:0]  g_inb = '0;
  logic [7:0]  g_td;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sha_byte_feeder #(.GAP(0), .ID_WIDTH(32)) dut0 (
    .clk(clk), .rstn(rstn), .i_valid(iv), .i_ready(ir), .i_last(il), .i_id(iid),
    .i_data(idat), .i_nbytes(inb), .tvalid(tv), .tready(trdy), .tlast(tl),
    .tid(tid), .tdata(td), .busy(busy));

  sha_byte_feeder #(.GAP(3), .ID_WIDTH(32)) dut3 (
    .clk(clk), .rstn(rstn), .i_valid(g_iv), .i_ready(g_ir), .i_last(g_il), .i_id(g_iid),
    .i_data(g_idat), .i_nbytes(g_inb), .tvalid(g_tv), .tready(g_trdy), .tlast(g_tl),
    .tid(g_tid), .tdata(g_td), .busy(g_busy));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iv = 1'b1; g_iv = 1'b1;
    @(negedge clk);
    tests++;
    if ({ir, tv, tl, tid, td, busy} !== 43'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {ir, tv, tl, tid, td, busy});
    end
    tests++;
    if ({g_ir, g_tv, g_tl, g_tid, g_td, g_busy} !== 43'd0) begin
      fails++; $display("FAIL reset_outputs_gap: got %h expected 0", {g_ir, g_tv, g_tl, g_tid, g_td, g_busy});
    end
    iv = 1'b0; g_iv = 1'b0;
    next_cycle();
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_abc();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63;
    iv = 1'b1; il = 1'b1; iid = 32'd111; idat = 32'h61626300; inb = 2'd2; trdy = 1'b1;
    @(negedge clk);
    tests++;
    if (ir !== 1'b1) begin fails++; $display("FAIL abc_idle_ready: got %b expected 1", ir); end
    next_cycle();
    iv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (tv !== 1'b1 || td !== exp_b[k] || tl !== (k == 2) || tid !== 32'd111 || busy !== 1'b1) begin
        fails++;
        $display("FAIL abc_byte%0d: got tv=%b td=%h tl=%b tid=%0d busy=%b expected tv=1 td=%h tl=%b tid=111 busy=1",
                 k, tv, td, tl, tid, busy, exp_b[k], (k == 2));
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if (tv !== 1'b0 || tid !== 32'd0 || td !== 8'd0 || tl !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abc_after: got tv=%b tid=%0d td=%h tl=%b busy=%b expected all 0", tv, tid, td, tl, busy);
    end
    next_cycle();
  endtask

  task automatic test_two_words();
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
    iv = 1'b1; il = 1'b0; iid = 32'd5; idat = 32'h11223344; inb = 2'd3; trdy = 1'b1;
    next_cycle();
    // Later-word id must be ignored.
    il = 1'b1; iid = 32'd99; idat = 32'h55660000; inb = 2'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (tv !== 1'b1 || td !== exp_b[k] || tl !== (k == 5) || tid !== 32'd5) begin
        fails++;
        $display("FAIL two_words_byte%0d: got tv=%b td=%h tl=%b tid=%0d expected tv=1 td=%h tl=%b tid=5",
                 k, tv, td, tl, tid, exp_b[k], (k == 5));
      end
      if (k <= 3) begin
        tests++;
        if (ir !== (k == 3)) begin
          fails++; $display("FAIL two_words_ready%0d: got %b expected %b", k, ir, (k == 3));
        end
      end
      next_cycle();
      if (k == 3) iv = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (tv !== 1'b0) begin fails++; $display("FAIL two_words_end: got tv=%b expected 0", tv); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [31:0] exp_id [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_id[0] = 32'd7; exp_id[1] = 32'd8; exp_id[2] = 32'd8;
    iv = 1'b1; il = 1'b1; iid = 32'd7; idat = 32'h11000000; inb = 2'd0; trdy = 1'b1;
    next_cycle();
    iid = 32'd8; idat = 32'h22330000; inb = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (tv !== 1'b1 || td !== exp_b[k] || tl !== (k != 1) || tid !== exp_id[k]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got tv=%b td=%h tl=%b tid=%0d expected tv=1 td=%h tl=%b tid=%0d",
                 k, tv, td, tl, tid, exp_b[k], (k != 1), exp_id[k]);
      end
      next_cycle();
      if (k == 0) iv = 1'b0;
    end
  endtask

  task automatic test_stall();
    int w = 0, cnt = 0, nlast = 0, cyc = 0;
    logic pstall = 1'b0;
    logic [7:0] ptd = '0;
    logic ptl = 1'b0;
    logic [31:0] ptid = '0;
    iid = 32'd222; inb = 2'd3;
    while (cnt < 64 && cyc < 3000) begin
      iv = (w < 16); il = (w == 15);
      idat = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      trdy = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      if (pstall) begin
        tests++;
        if (tv !== 1'b1 || td !== ptd || tl !== ptl || tid !== ptid) begin
          fails++;
          $display("FAIL stall_hold: got tv=%b td=%h tl=%b tid=%0d expected tv=1 td=%h tl=%b tid=%0d",
                   tv, td, tl, tid, ptd, ptl, ptid);
        end
      end
      if (tv && trdy) begin
        tests++;
        if (td !== 8'(cnt) || tl !== (cnt == 63) || tid !== 32'd222) begin
          fails++;
          $display("FAIL stall_byte%0d: got td=%h tl=%b tid=%0d expected td=%h tl=%b tid=222",
                   cnt, td, tl, tid, 8'(cnt), (cnt == 63));
        end
        if (tl) nlast++;
        cnt++;
        pstall = 1'b0;
      end else begin
        pstall = tv; ptd = td; ptl = tl; ptid = tid;
      end
      if (iv && ir) w++;
      next_cycle();
      cyc++;
    end
    iv = 1'b0; trdy = 1'b1;
    tests++;
    if (cnt != 64) begin fails++; $display("FAIL stall_count: got %0d expected 64", cnt); end
    tests++;
    if (nlast != 1) begin fails++; $display("FAIL stall_tlast_count: got %0d expected 1", nlast); end
    @(negedge clk);
    tests++;
    if (tv !== 1'b0) begin fails++; $display("FAIL stall_end: got tv=%b expected 0", tv); end
    next_cycle();
  endtask

  task automatic test_gap();
    g_iv = 1'b1; g_il = 1'b1; g_iid = 32'd333; g_idat = 32'hAA000000; g_inb = 2'd0; g_trdy = 1'b1;
    @(negedge clk);
    tests++;
    if (g_ir !== 1'b1) begin fails++; $display("FAIL gap_idle_ready: got %b expected 1", g_ir); end
    next_cycle();
    g_iid = 32'd444; g_idat = 32'hBB000000;
    @(negedge clk);
    tests++;
    if (g_tv !== 1'b1 || g_td !== 8'hAA || g_tl !== 1'b1 || g_tid !== 32'd333 || g_ir !== 1'b0) begin
      fails++;
      $display("FAIL gap_msg1: got tv=%b td=%h tl=%b tid=%0d ready=%b expected 1 aa 1 333 0",
               g_tv, g_td, g_tl, g_tid, g_ir);
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (g_ir !== 1'b0 || g_tv !== 1'b0 || g_busy !== 1'b1) begin
        fails++; $display("FAIL gap_idle%0d: got ready=%b tv=%b busy=%b expected 0 0 1", k, g_ir, g_tv, g_busy);
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if (g_ir !== 1'b1 || g_busy !== 1'b0) begin
      fails++; $display("FAIL gap_release: got ready=%b busy=%b expected 1 0", g_ir, g_busy);
    end
    next_cycle();
    g_iv = 1'b0;
    @(negedge clk);
    tests++;
    if (g_tv !== 1'b1 || g_td !== 8'hBB || g_tl !== 1'b1 || g_tid !== 32'd444) begin
      fails++;
      $display("FAIL gap_msg2: got tv=%b td=%h tl=%b tid=%0d expected 1 bb 1 444", g_tv, g_td, g_tl, g_tid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (g_tv !== 1'b0 || g_ir !== 1'b0) begin
      fails++; $display("FAIL gap_after_msg2: got tv=%b ready=%b expected 0 0", g_tv, g_ir);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63;
    iv = 1'b1; il = 1'b1; iid = 32'd555; idat = 32'h01020304; inb = 2'd3; trdy = 1'b1;
    next_cycle();
    iv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (td !== 8'(k + 1) || tid !== 32'd555 || tl !== 1'b0) begin
        fails++; $display("FAIL rstmid_byte%0d: got td=%h tid=%0d tl=%b expected %h 555 0", k, td, tid, tl, 8'(k + 1));
      end
      next_cycle();
    end
    rstn = 1'b0;
    #1;
    tests++;
    if ({ir, tv, tl, tid, td, busy} !== 43'd0) begin
      fails++; $display("FAIL rstmid_outputs: got %h expected 0", {ir, tv, tl, tid, td, busy});
    end
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    iv = 1'b1; il = 1'b1; iid = 32'd666; idat = 32'h61626300; inb = 2'd2;
    next_cycle();
    iv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (tv !== 1'b1 || td !== exp_b[k] || tl !== (k == 2) || tid !== 32'd666) begin
        fails++;
        $display("FAIL rstmid_abc%0d: got tv=%b td=%h tl=%b tid=%0d expected 1 %h %b 666",
                 k, tv, td, tl, tid, exp_b[k], (k == 2));
      end
      next_cycle();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_abc();
    test_two_words();
    test_back_to_back();
    test_stall();
    test_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
